// File: rtl/frame_ingress_arbiter_if.sv
// Bus bundle for frame_ingress_arbiter: RX FIFO read side, body FIFO write
// side, descriptor FIFO write side and per-port frame counters.
// master = arbiter side, slave = FIFO/environment side.
interface frame_ingress_arbiter_if #(
  parameter int PORT_NUM = 4,
  parameter int PORT_W   = 2,
  parameter int LEN_W    = 16
);
  logic [8*PORT_NUM-1:0]   in_fifo_dout;
  logic [PORT_NUM-1:0]     in_fifo_empty;
  logic [PORT_NUM-1:0]     in_fifo_frame_exist;
  logic [PORT_NUM-1:0]     in_fifo_eod;
  logic [PORT_NUM-1:0]     in_fifo_rden;
  logic [7:0]              b_fifo_din;
  logic                    b_fifo_wren;
  logic                    b_fifo_del;
  logic                    b_fifo_afull;
  logic [LEN_W+PORT_W-1:0] d_fifo_din;
  logic                    d_fifo_wren;
  logic                    d_fifo_full;
  logic [16*PORT_NUM-1:0]  frame_cnt;

  modport master (
    input  in_fifo_dout, in_fifo_empty, in_fifo_frame_exist, in_fifo_eod,
    input  b_fifo_afull, d_fifo_full,
    output in_fifo_rden, b_fifo_din, b_fifo_wren, b_fifo_del,
    output d_fifo_din, d_fifo_wren, frame_cnt
  );

  modport slave (
    output in_fifo_dout, in_fifo_empty, in_fifo_frame_exist, in_fifo_eod,
    output b_fifo_afull, d_fifo_full,
    input  in_fifo_rden, b_fifo_din, b_fifo_wren, b_fifo_del,
    input  d_fifo_din, d_fifo_wren, frame_cnt
  );
endinterface

// File: rtl/frame_ingress_arbiter.sv
// N-port frame ingress arbiter: frame-granular round-robin over the RX FIFOs,
// byte copy into the body FIFO (EOD preserved), then one {len, src} descriptor.
// Optional per-port accepted-frame counters under macro INGRESS_STATS_EN.
//
// Read pacing: rden is registered and the RX FIFO answers one clock later, so
// S_RD is the cycle rden is on the bus and S_CAP is the cycle the byte is on
// in_fifo_dout. b_fifo_wren is the registered follow-on of rden; b_fifo_din and
// b_fifo_del pass the (already FIFO-registered) granted byte through, gated by
// wren, so they stay 0 outside a write. S_CAP may issue the next read directly,
// giving one byte every 2 clocks with never more than one read in flight.
module frame_ingress_arbiter #(
  parameter int PORT_NUM = 4,
  parameter int PORT_W   = 2,
  parameter int LEN_W    = 16
) (
  input logic clk,
  input logic rst,
  frame_ingress_arbiter_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_DESC = 3'd4;

  localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
  localparam logic [PORT_W-1:0] LAST_RST = PORT_W'(PORT_NUM - 1);

  logic [2:0]              state_q, state_d;
  logic [PORT_W-1:0]       gnt_q, gnt_d;
  logic [PORT_W-1:0]       last_q, last_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [PORT_NUM-1:0]     rden_q, rden_d;
  logic                    b_wren_q, b_wren_d;
  logic [LEN_W+PORT_W-1:0] d_din_q, d_din_d;
  logic                    d_wren_q, d_wren_d;

  logic                    hit_hi, hit_lo, scan_hit;
  logic [PORT_W-1:0]       port_hi, port_lo, scan_port;
  logic [PORT_NUM-1:0]     gnt_onehot;
  logic [7:0]              cur_byte;
  logic                    cur_eod, cur_empty, can_read;

  // Granted-port mux: one-hot grant, byte, EOD and empty flag of that port.
  always_comb begin
    gnt_onehot = '0;
    cur_byte   = '0;
    cur_eod    = 1'b0;
    cur_empty  = 1'b1;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (PORT_W'(p) == gnt_q) begin
        gnt_onehot[p] = 1'b1;
        cur_byte      = bus.in_fifo_dout[8*p +: 8];
        cur_eod       = bus.in_fifo_eod[p];
        cur_empty     = bus.in_fifo_empty[p];
      end
    end
  end

  assign can_read = !cur_empty && !bus.b_fifo_afull;

  // Round-robin scan: first port above last_q wins, otherwise wrap to the lowest.
  always_comb begin
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    port_hi = '0;
    port_lo = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (bus.in_fifo_frame_exist[p]) begin
        if (PORT_W'(p) > last_q) begin
          if (!hit_hi) begin
            hit_hi  = 1'b1;
            port_hi = PORT_W'(p);
          end
        end else if (!hit_lo) begin
          hit_lo  = 1'b1;
          port_lo = PORT_W'(p);
        end
      end
    end
    scan_hit  = hit_hi | hit_lo;
    scan_port = hit_hi ? port_hi : port_lo;
  end

  // Next-state and registered-output decode for the frame transfer FSM.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    len_d    = len_q;
    rden_d   = '0;
    b_wren_d = 1'b0;
    d_wren_d = 1'b0;
    d_din_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (scan_hit) begin
          gnt_d   = scan_port;
          last_d  = scan_port;
          len_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (can_read) begin
          rden_d  = gnt_onehot;
          state_d = S_RD;
        end
      end
      S_RD: begin
        b_wren_d = 1'b1;
        state_d  = S_CAP;
      end
      S_CAP: begin
        if (len_q != LEN_MAX) len_d = len_q + LEN_W'(1);
        if (cur_eod) begin
          state_d = S_DESC;
        end else if (can_read) begin
          rden_d  = gnt_onehot;
          state_d = S_RD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DESC: begin
        if (!bus.d_fifo_full) begin
          d_wren_d = 1'b1;
          d_din_d  = {len_q, gnt_q};
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset leaves port 0 first in the rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      last_q   <= LAST_RST;
      len_q    <= '0;
      rden_q   <= '0;
      b_wren_q <= 1'b0;
      d_din_q  <= '0;
      d_wren_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      len_q    <= len_d;
      rden_q   <= rden_d;
      b_wren_q <= b_wren_d;
      d_din_q  <= d_din_d;
      d_wren_q <= d_wren_d;
    end
  end

  assign bus.in_fifo_rden = rden_q;
  assign bus.b_fifo_wren  = b_wren_q;
  assign bus.b_fifo_din   = b_wren_q ? cur_byte : '0;
  assign bus.b_fifo_del   = b_wren_q & cur_eod;
  assign bus.d_fifo_wren  = d_wren_q;
  assign bus.d_fifo_din   = d_din_q;

`ifdef INGRESS_STATS_EN
  logic [15:0] cnt_q [PORT_NUM];

  // Per-port frame counters, bumped on the edge that launches the descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) cnt_q[p] <= '0;
    end else if (d_wren_d) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (PORT_W'(p) == gnt_q) cnt_q[p] <= cnt_q[p] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_cnt
    assign bus.frame_cnt[16*g +: 16] = cnt_q[g];
  end
`else
  assign bus.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_ingress_arbiter.sv
// Scoreboard bench for frame_ingress_arbiter: behavioural RX FIFOs (1-clk read
// latency), directed frames whose expected bytes/descriptors are queued at
// load time, and a negedge monitor that pops and compares every write.
`timescale 1ns/1ps
module tb_frame_ingress_arbiter;
  localparam int PORT_NUM = 4;
  localparam int PORT_W   = 2;
  localparam int LEN_W    = 16;
  localparam int DW       = LEN_W + PORT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_ingress_arbiter_if #(.PORT_NUM(PORT_NUM), .PORT_W(PORT_W), .LEN_W(LEN_W)) bus ();

  frame_ingress_arbiter #(.PORT_NUM(PORT_NUM), .PORT_W(PORT_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // RX FIFO model: {eod, byte} entries per port.
  logic [8:0] fq [PORT_NUM][$];
  logic [8:0] mw;
  logic       hide;

  function automatic bit has_eod(input int p);
    for (int i = 0; i < fq[p].size(); i++) begin
      logic [8:0] e;
      e = fq[p][i];
      if (e[8]) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (rst) begin
          bus.in_fifo_dout[8*p +: 8] <= '0;
          bus.in_fifo_eod[p]         <= 1'b0;
        end else if (bus.in_fifo_rden[p] && fq[p].size() > 0) begin
          mw = fq[p].pop_front();
          bus.in_fifo_dout[8*p +: 8] <= mw[7:0];
          bus.in_fifo_eod[p]         <= mw[8];
        end
      end
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        bus.in_fifo_empty[p]       <= (fq[p].size() == 0);
        bus.in_fifo_frame_exist[p] <= !hide && has_eod(p);
      end
    end
  end

  // Scoreboard queues and monitor.
  logic [8:0]    exp_b [$];
  logic [DW-1:0] exp_d [$];
  int  b_wr_cnt = 0;
  int  d_wr_cnt = 0;
  int  cyc = 0;
  int  last_wr_cyc = 0;
  bit  have_last = 1'b0;
  bit  prev_rd = 1'b0;
  bit  gap_en;
  logic [8:0]    eb;
  logic [DW-1:0] ed;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_rd   = 1'b0;
      have_last = 1'b0;
    end else begin
      chk("wren_follows_rden", bus.b_fifo_wren, prev_rd);
      if (bus.in_fifo_rden != '0) chk("rden_onehot", $onehot(bus.in_fifo_rden), 1);
      prev_rd = |bus.in_fifo_rden;
      if (bus.b_fifo_wren) begin
        b_wr_cnt++;
        if (gap_en && have_last) chk("byte_gap", cyc - last_wr_cyc, 2);
        last_wr_cyc = cyc;
        have_last   = !bus.b_fifo_del;
        chk("body_write_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) begin
          eb = exp_b.pop_front();
          chk("body_del_byte", {bus.b_fifo_del, bus.b_fifo_din}, eb);
        end
      end
      if (bus.d_fifo_wren) begin
        d_wr_cnt++;
        chk("desc_write_expected", exp_d.size() != 0, 1);
        if (exp_d.size() != 0) begin
          ed = exp_d.pop_front();
          chk("descriptor", bus.d_fifo_din, ed);
        end
      end
    end
  end

  // Queue a frame of n bytes base, base+1, ... on port p plus its expectations.
  task automatic load(input int p, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic [8:0] w;
      w = {(i == n - 1), 8'(base + 8'(i))};
      fq[p].push_back(w);
      exp_b.push_back(w);
    end
    exp_d.push_back({LEN_W'(n), PORT_W'(p)});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_b.size() != 0 || exp_d.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk({name, "_drained"}, exp_b.size() + exp_d.size(), 0);
    exp_b.delete();
    exp_d.delete();
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int s = b_wr_cnt;
    int k = 0;
    while (b_wr_cnt - s < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_reached"}, (b_wr_cnt - s) >= n, 1);
  endtask

  task automatic clear_all();
    for (int p = 0; p < PORT_NUM; p++) fq[p].delete();
    exp_b.delete();
    exp_d.delete();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_rden"},  bus.in_fifo_rden, 0);
    chk({name, "_bwren"}, bus.b_fifo_wren, 0);
    chk({name, "_bdin"},  bus.b_fifo_din, 0);
    chk({name, "_bdel"},  bus.b_fifo_del, 0);
    chk({name, "_dwren"}, bus.d_fifo_wren, 0);
    chk({name, "_ddin"},  bus.d_fifo_din, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ds;
    logic [63:0] cnt_exp;
    bus.b_fifo_afull = 1'b0;
    bus.d_fifo_full  = 1'b0;
    hide   = 1'b0;
    gap_en = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_frame_cnt", bus.frame_cnt, 0);
    rst = 1'b0;

    // 1: single 64-byte frame on port 2, bytes every 2 clk
    gap_en = 1'b1;
    load(2, 64, 8'h00);
    wait_drain("t1", 400);
    gap_en = 1'b0;

    // 2: ports 0,1,3 ready together after reset -> 0,1,3
    rst = 1'b1;
    @(negedge clk);
    clear_all();
    load(0, 60, 8'h40);
    load(1, 60, 8'h80);
    load(3, 60, 8'hC0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_drain("t2", 1200);

    // 3: fairness, port 0 with 3 frames and port 1 with 2 -> 0,1,0,1,0
    hide = 1'b1;
    load(0, 5, 8'h10);
    load(1, 5, 8'h50);
    load(0, 5, 8'h20);
    load(1, 5, 8'h60);
    load(0, 5, 8'h30);
    repeat (2) @(negedge clk);
    hide = 1'b0;
    wait_drain("t3", 400);

    // 4: body afull hold mid-frame, then descriptor FIFO full at end
    bus.d_fifo_full = 1'b1;
    load(2, 40, 8'hA0);
    wait_writes("t4_pre_afull", 10, 200);
    bus.b_fifo_afull = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("afull_no_rden", bus.in_fifo_rden, 0);
        chk("afull_no_wren", bus.b_fifo_wren, 0);
      end
    end
    bus.b_fifo_afull = 1'b0;
    for (int k = 0; k < 300 && exp_b.size() != 0; k++) @(negedge clk);
    chk("t4_body_done", exp_b.size(), 0);
    ds = d_wr_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("dfull_no_dwren", bus.d_fifo_wren, 0);
      chk("dfull_no_rden", bus.in_fifo_rden, 0);
    end
    bus.d_fifo_full = 1'b0;
    wait_drain("t4", 50);
    repeat (3) @(negedge clk);
    chk("t4_single_desc", d_wr_cnt - ds, 1);

    // 5: reset after byte 10 of a 100-byte frame on port 1
    load(1, 100, 8'h00);
    wait_writes("t5_pre_reset", 10, 200);
    #1 rst = 1'b1;
    #1 chk_outputs_zero("async_reset");
    clear_all();
    repeat (3) @(negedge clk);
    load(0, 8, 8'h11);
    load(3, 4, 8'h22);
    @(negedge clk);
    rst = 1'b0;
    wait_drain("t5", 200);

    // 6: stats, port 1 x3 and port 3 x1 after reset -> order 1,3,1,1
    rst = 1'b1;
    @(negedge clk);
    clear_all();
    load(1, 3, 8'h70);
    load(3, 3, 8'h90);
    load(1, 3, 8'h74);
    load(1, 3, 8'h78);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_drain("t6", 300);
`ifdef INGRESS_STATS_EN
    cnt_exp = {16'd1, 16'd0, 16'd3, 16'd0};
`else
    cnt_exp = '0;
`endif
    chk("frame_cnt", bus.frame_cnt, cnt_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
